// File: rtl/bitblade_shift_accumulator_if.sv
// Beat-in / result-out bundle for the BitBlade shift accumulator.
// The master drives beats and consumes results; the slave is the accumulator.
interface bitblade_shift_accumulator_if #(
   parameter int unsigned PSUM_W  = 8,
   parameter int unsigned ACC_W   = 24,
   parameter int unsigned SHIFT_W = 4
);
   logic [3:0]         cfg_len;
   logic               in_valid;
   logic               in_ready;
   logic [PSUM_W-1:0]  psum_in;
   logic [SHIFT_W-1:0] shift_in;
   logic               out_valid;
   logic               out_ready;
   logic [ACC_W-1:0]   acc_out;
   logic               ovf_out;

   modport master (
      output cfg_len,
      output in_valid,
      output psum_in,
      output shift_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  acc_out,
      input  ovf_out
   );

   modport slave (
      input  cfg_len,
      input  in_valid,
      input  psum_in,
      input  shift_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output acc_out,
      output ovf_out
   );
endinterface

// File: rtl/bitblade_shift_accumulator.sv
// Shift-add accumulator behind the bit-brick array: sign-extends, shifts and sums
// a configurable number of partial-sum beats, then holds the result until taken.
module bitblade_shift_accumulator #(
   parameter int unsigned PSUM_W  = 8,
   parameter int unsigned ACC_W   = 24,
   parameter int unsigned SHIFT_W = 4
) (
   input logic                          clk,
   input logic                          rst,
   bitblade_shift_accumulator_if.slave  io_bus
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [0:0] {
      StAccum = 1'b0,
      StHold  = 1'b1
   } state_e;

   state_e             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_len_q;
   logic [ACC_W-1:0]   r_acc;
   logic               r_ovf;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [ACC_W-1:0]   r_acc_out;
   logic               r_ovf_out;

   logic               w_accept;
   logic               w_first;
   logic [CNT_W-1:0]   w_cfg_last;
   logic [CNT_W-1:0]   w_len;
   logic               w_last;
   logic [ACC_W-1:0]   w_ext;
   logic [ACC_W-1:0]   w_term;
   logic [ACC_W-1:0]   w_base_acc;
   logic               w_base_ovf;
   logic [ACC_W-1:0]   w_sum;
   logic               w_ovf_step;
   logic               w_ovf;

   assign w_accept   = io_bus.in_valid && r_in_ready;
   assign w_first    = (r_cnt == '0);
   assign w_cfg_last = io_bus.cfg_len - 4'd1;
   // The first beat compares against the live config; later beats use the latched length.
   assign w_len      = w_first ? w_cfg_last : r_len_q;
   assign w_last     = (r_cnt == w_len);

   assign w_ext  = {{(ACC_W-PSUM_W){io_bus.psum_in[PSUM_W-1]}}, io_bus.psum_in};
   assign w_term = w_ext << io_bus.shift_in;

   // A new group starts from zero regardless of what the previous group left behind.
   assign w_base_acc = w_first ? '0 : r_acc;
   assign w_base_ovf = w_first ? 1'b0 : r_ovf;
   assign w_sum      = w_base_acc + w_term;

   assign w_ovf_step = (w_base_acc[ACC_W-1] == w_term[ACC_W-1]) &&
                       (w_sum[ACC_W-1] != w_base_acc[ACC_W-1]);
   assign w_ovf      = w_base_ovf | w_ovf_step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StAccum;
         r_cnt       <= '0;
         r_len_q     <= '0;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_acc_out   <= '0;
         r_ovf_out   <= 1'b0;
      end else begin
         unique case (r_state)
            StAccum: begin
               if (w_accept) begin
                  if (w_first) begin
                     r_len_q <= w_cfg_last;
                  end
                  r_acc <= w_sum;
                  r_ovf <= w_ovf;
                  if (w_last) begin
                     r_acc_out   <= w_sum;
                     r_ovf_out   <= w_ovf;
                     r_cnt       <= '0;
                     r_state     <= StHold;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
            end
            StHold: begin
               if (io_bus.out_ready) begin
                  r_state     <= StAccum;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= StAccum;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.in_ready  = r_in_ready;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.acc_out   = r_acc_out;
   assign io_bus.ovf_out   = r_ovf_out;

   a_hold_stable: assert property (@(posedge clk) disable iff (rst)
      (r_out_valid && !io_bus.out_ready) |=> (r_out_valid && $stable(r_acc_out) &&
                                              $stable(r_ovf_out)));

   a_ready_exclusive: assert property (@(posedge clk) disable iff (rst)
      r_in_ready != r_out_valid);

endmodule

// File: tb/tb_bitblade_shift_accumulator.sv
// Randomised scoreboard bench for bitblade_shift_accumulator with directed groups
// for weighting, sign, back-pressure, length wrap, overflow and mid-group reset.
module tb_bitblade_shift_accumulator;

   localparam int unsigned PSUM_W  = 8;
   localparam int unsigned ACC_W   = 24;
   localparam int unsigned SHIFT_W = 4;

   typedef struct {
      logic [ACC_W-1:0] acc;
      logic             ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   bitblade_shift_accumulator_if #(
      .PSUM_W (PSUM_W),
      .ACC_W  (ACC_W),
      .SHIFT_W(SHIFT_W)
   ) bus ();

   bitblade_shift_accumulator #(
      .PSUM_W (PSUM_W),
      .ACC_W  (ACC_W),
      .SHIFT_W(SHIFT_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .io_bus(bus)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   // Reference model state: value of the running sum as a true signed integer.
   longint m_acc;
   bit     m_ovf;
   int     m_cnt;
   int     m_len;

   // Directed groups may pin the expected result to a hand-computed constant.
   bit               k_en  = 1'b0;
   logic [ACC_W-1:0] k_acc = '0;
   bit               k_ovf = 1'b0;

   bit bp_low  = 1'b0;
   bit bp_rand = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send_beat(input logic [3:0] cfg, input int p, input int s);
      int                  n;
      logic signed [7:0]   ps;
      logic signed [23:0]  ts;
      logic signed [23:0]  w;
      longint              t;
      longint              sum;
      exp_t                e;
      #1;
      bus.cfg_len  = cfg;
      bus.psum_in  = p[7:0];
      bus.shift_in = s[3:0];
      bus.in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL beat_accept_timeout: in_ready stuck at 0, required 1");
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      if (m_cnt == 0) begin
         m_len = (cfg == 4'd0) ? 16 : int'(cfg);
         m_acc = 0;
         m_ovf = 1'b0;
      end
      ps  = p[7:0];
      t   = longint'(ps) * (64'sd1 << s);
      ts  = t[23:0];
      sum = m_acc + longint'(ts);
      if (sum > 64'sd8388607 || sum < -64'sd8388608) m_ovf = 1'b1;
      w     = sum[23:0];
      m_acc = longint'(w);
      m_cnt++;
      if (m_cnt == m_len) begin
         if (k_en) begin
            e.acc = k_acc;
            e.ovf = k_ovf;
         end else begin
            e.acc = w;
            e.ovf = m_ovf;
         end
         exp_q.push_back(e);
         m_cnt = 0;
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         n++;
         @(posedge clk);
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      #1;
   endtask

   // Consumer side: out_ready follows the current back-pressure mode.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = bp_low ? 1'b0 : (bp_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   // Monitor: compares every presented result against the scoreboard head.
   initial begin : monitor
      bit rel_pending;
      rel_pending = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rel_pending = 1'b0;
         end else begin
            if (rel_pending) begin
               chk("in_ready_after_release", 32'(bus.in_ready), 32'd1);
               chk("out_valid_after_release", 32'(bus.out_valid), 32'd0);
               rel_pending = 1'b0;
            end
            chk("in_ready_vs_out_valid", 32'(bus.in_ready), 32'(!bus.out_valid));
            if (bus.out_valid) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_result: acc_out %0h presented, none expected",
                           bus.acc_out);
               end else begin
                  chk("acc_out", 32'(bus.acc_out), 32'(exp_q[0].acc));
                  chk("ovf_out", 32'(bus.ovf_out), 32'(exp_q[0].ovf));
                  if (bus.out_ready) begin
                     void'(exp_q.pop_front());
                     rel_pending = 1'b1;
                  end
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.cfg_len  = 4'd0;
      bus.psum_in  = '0;
      bus.shift_in = '0;
      m_acc = 0;
      m_ovf = 1'b0;
      m_cnt = 0;
      m_len = 16;

      #12;
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_acc_out", 32'(bus.acc_out), 32'd0);
      chk("reset_ovf_out", 32'(bus.ovf_out), 32'd0);
      @(posedge clk);
      #3 rst = 1'b0;

      // Unsigned weighting: 1+2+4+8.
      k_en = 1'b1; k_acc = 24'd15; k_ovf = 1'b0;
      for (int i = 0; i < 4; i++) send_beat(4'd4, 1, i);
      chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1 chk("one_cycle_out_valid", 32'(bus.out_valid), 32'd0);

      // Signed mix: -1<<4 + 3.
      k_acc = 24'hFFFFF3;
      send_beat(4'd2, -1, 4);
      send_beat(4'd2, 3, 0);
      wait_drain();

      // Back-pressure with a beat waiting; next group must not include the held value.
      bp_low = 1'b1;
      k_acc  = 24'd5;
      send_beat(4'd1, 5, 0);
      fork
         begin
            repeat (5) @(negedge clk);
            bp_low = 1'b0;
         end
      join_none
      k_acc = 24'd2;
      send_beat(4'd2, 1, 0);
      send_beat(4'd2, 1, 0);
      wait_drain();

      // Length wrap: cfg_len 0 means 16 beats.
      k_acc = 24'd16;
      for (int i = 0; i < 16; i++) begin
         send_beat(4'd0, 1, 0);
         if (i == 14) chk("no_early_out_valid", 32'(bus.out_valid), 32'd0);
      end
      wait_drain();

      // Single-beat group.
      k_acc = 24'hFFFF80;
      send_beat(4'd1, -128, 0);
      chk("single_beat_valid", 32'(bus.out_valid), 32'd1);
      wait_drain();

      // Overflow then a clean group.
      k_acc = 24'hBE8000; k_ovf = 1'b1;
      for (int i = 0; i < 3; i++) send_beat(4'd3, 127, 15);
      wait_drain();
      k_acc = 24'd3; k_ovf = 1'b0;
      send_beat(4'd2, 1, 0);
      send_beat(4'd2, 2, 0);
      wait_drain();

      // Reset mid-group: partial group is discarded, outputs cleared immediately.
      send_beat(4'd4, 5, 0);
      send_beat(4'd4, 5, 0);
      @(posedge clk);
      #3 rst = 1'b1;
      m_cnt = 0;
      #1;
      chk("midreset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midreset_acc_out", 32'(bus.acc_out), 32'd0);
      chk("midreset_ovf_out", 32'(bus.ovf_out), 32'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      k_acc = 24'd8;
      for (int i = 0; i < 4; i++) send_beat(4'd4, 2, 0);
      wait_drain();

      // Random groups with random back-pressure, gaps and mid-group cfg_len noise.
      k_en    = 1'b0;
      bp_rand = 1'b1;
      for (int g = 0; g < 40; g++) begin
         logic [3:0] cfg;
         int         nb;
         cfg = 4'($urandom_range(0, 15));
         nb  = (cfg == 4'd0) ? 16 : int'(cfg);
         for (int b = 0; b < nb; b++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(posedge clk);
            send_beat((b == 0) ? cfg : 4'($urandom_range(0, 15)),
                      int'($urandom_range(0, 255)) - 128,
                      int'($urandom_range(0, 15)));
         end
      end
      bp_rand = 1'b0;
      wait_drain();

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
